// File: rtl/ksa_ctrl.sv
// ksa_ctrl: RC4 key-scheduling sequencer that owns a single-port 256x8 S-memory.
// Define KSA_INIT_EN to include the S[k]=k fill phase; without it S must already hold the identity.
module ksa_ctrl #(
  parameter int KEY_BYTES  = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [DATA_WIDTH-1:0]  mem_q,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]  mem_data,
  output logic                   mem_wren,
  output logic                   busy,
  output logic                   done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  i;
  logic [ADDR_WIDTH-1:0]  j;
  logic [ADDR_WIDTH-1:0]  j_next;
  logic [DATA_WIDTH-1:0]  si;
  logic [KW-1:0]          kidx;
  logic [KEY_BYTES*8-1:0] key_reg;
  logic [7:0]             kbyte;

  // Byte 0 is the most significant byte of the latched key.
  always_comb begin
    kbyte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KW'(b)) kbyte = key_reg[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  assign j_next = j + ADDR_WIDTH'(mem_q) + ADDR_WIDTH'(kbyte);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      si          <= '0;
      kidx        <= '0;
      key_reg     <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_reg     <= secret_key;
            i           <= '0;
            j           <= '0;
            kidx        <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            mem_address <= '0;
            mem_data    <= '0;
`ifdef KSA_INIT_EN
            state       <= INIT;
            mem_wren    <= 1'b1;
`else
            state       <= RD_I;
            mem_wren    <= 1'b0;
`endif
          end
        end
        INIT: begin
          if (i == '1) begin
            state       <= RD_I;
            i           <= '0;
            j           <= '0;
            mem_address <= '0;
            mem_wren    <= 1'b0;
          end else begin
            i           <= i + ONE;
            mem_address <= i + ONE;
            mem_data    <= DATA_WIDTH'(i + ONE);
          end
        end
        RD_I: state <= GET_I;
        // Present the new j straight away so S[j] is read in the next cycle.
        GET_I: begin
          si          <= mem_q;
          j           <= j_next;
          mem_address <= j_next;
          state       <= RD_J;
        end
        RD_J: state <= GET_J;
        GET_J: begin
          mem_address <= i;
          mem_data    <= mem_q;
          mem_wren    <= 1'b1;
          state       <= WR_I;
        end
        WR_I: begin
          mem_address <= j;
          mem_data    <= si;
          state       <= WR_J;
        end
        WR_J: begin
          mem_wren <= 1'b0;
          if (i == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i           <= i + ONE;
            mem_address <= i + ONE;
            kidx        <= (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + KW'(1);
            state       <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_ctrl.sv
// Scoreboard bench for ksa_ctrl: a plain software KSA predicts every memory write and the done edge.
module tb_ksa_ctrl;

`ifdef KSA_INIT_EN
  localparam bit HAS_INIT = 1'b1;
`else
  localparam bit HAS_INIT = 1'b0;
`endif
  localparam int B = HAS_INIT ? 256 : 0;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  mem_q;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;

  ksa_ctrl #(.KEY_BYTES(3), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .secret_key(secret_key),
    .mem_q(mem_q), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural S-memory: registered read, write at the clock edge.
  logic [7:0] mem      [256];
  logic [7:0] fill_val [256];
  logic [7:0] ref_s    [256];
  bit         fill_req = 1'b0;

  always @(posedge clock) begin
    if (fill_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= fill_val[k];
    end else if (mem_wren) begin
      mem[mem_address] <= mem_data;
    end
    mem_q <= mem[mem_address];
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         at;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every done edge is matched against the scoreboard.
  logic done_q = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_wren) begin
        if (exp_wr.size() == 0) begin
          check("wr_pending", exp_wr.size(), 1);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr_data", {mem_address, mem_data}, {e.addr, e.data});
          check("wr_cycle", cyc + 1, e.at);
        end
      end
      if (done && !done_q) begin
        if (exp_done.size() == 0) begin
          check("done_pending", exp_done.size(), 1);
        end else begin
          check("done_cycle", cyc, exp_done.pop_front());
          check("busy_at_done", busy, 0);
        end
      end
    end
    done_q <= done;
  end

  // Reference KSA on an array; acc is the number of the accepting edge.
  task automatic push_model(input logic [23:0] key, input int acc);
    int jj;
    logic [7:0] si, sj, kb;
    if (HAS_INIT) begin
      for (int k = 0; k < 256; k++) begin
        exp_wr.push_back('{addr: 8'(k), data: 8'(k), at: acc + k + 1});
        ref_s[k] = 8'(k);
      end
    end
    jj = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      jj = (jj + int'(ref_s[i]) + int'(kb)) % 256;
      si = ref_s[i];
      sj = ref_s[jj];
      exp_wr.push_back('{addr: 8'(i),  data: sj, at: acc + B + 6*i + 5});
      exp_wr.push_back('{addr: 8'(jj), data: si, at: acc + B + 6*i + 6});
      ref_s[i]  = sj;
      ref_s[jj] = si;
    end
    exp_done.push_back(acc + B + 1536);
  endtask

  task automatic preload();
    for (int k = 0; k < 256; k++) begin
      fill_val[k] = HAS_INIT ? 8'($urandom) : 8'(k);
      ref_s[k]    = fill_val[k];
    end
    @(negedge clock); fill_req = 1'b1;
    @(negedge clock); fill_req = 1'b0;
  endtask

  task automatic issue(input logic [23:0] key, input bit hold);
    int acc;
    @(negedge clock);
    acc = cyc + 1;
    push_model(key, acc);
    if (hold) push_model(key, acc + B + 1536 + 1);
    secret_key = key;
    start      = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 4000);
    check("done_seen", done, 1);
  endtask

  task automatic check_final();
    int nmis = 0;
    int ndist = 0;
    bit seen [256];
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== ref_s[k]) nmis++;
      if (!seen[mem[k]]) begin
        seen[mem[k]] = 1'b1;
        ndist++;
      end
    end
    check("final_mem_mismatches", nmis, 0);
    check("final_mem_distinct", ndist, 256);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; secret_key = '0;
    repeat (3) @(posedge clock);
    #1 check("reset_state", {mem_address, mem_data, mem_wren, busy, done}, 0);
    @(negedge clock) reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("idle_outputs", {mem_address, mem_wren, busy, done}, 0);
    end

    // All-zero key
    preload();
    issue(24'h000000, 1'b0);
    check("busy_after_start", {busy, done}, 2'b10);
`ifdef KSA_INIT_EN
    begin
      int nbad = 0;
      repeat (255) @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 256; k++) if (mem[k] !== 8'(k)) nbad++;
      check("init_identity", nbad, 0);
    end
`endif
    wait_done();
    check_final();

    for (int r = 0; r < 20; r++) begin
      preload();
      issue(24'($urandom), 1'b0);
      wait_done();
      check_final();
    end

    // Reset in the middle of a run, then a clean rerun
    preload();
    issue(24'($urandom), 1'b0);
    repeat (899) @(posedge clock);
    #2 reset = 1'b1;
    exp_wr.delete();
    exp_done.delete();
    #1 check("reset_midrun_outputs", {mem_address, mem_data, mem_wren, busy, done}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("reset_held_outputs", {mem_address, mem_data, mem_wren, busy, done}, 0);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("post_reset_idle", {mem_wren, busy, done}, 0);
    end
    preload();
    issue(24'hA5C3_17, 1'b0);
    wait_done();
    check_final();

    // A start pulse mid-run must be ignored
    preload();
    issue(24'h1234_56, 1'b0);
    repeat (100) @(posedge clock);
    #1 secret_key = 24'($urandom); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("midrun_start_ignored", {busy, done}, 2'b10);
    wait_done();
    check_final();

    // start held across DONE restarts immediately
    preload();
    issue(24'hFEDC_BA, 1'b1);
    wait_done();
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("restart_done_one_cycle", {busy, done}, 2'b10);
    wait_done();
    check_final();

    repeat (5) @(negedge clock);
    check("leftover_writes", exp_wr.size(), 0);
    check("leftover_done", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ksa_ctrl.md
Name: ksa_ctrl

Overview:
Sequencer that owns the single-port 256x8 S-memory (1-cycle registered read, write committed at clock edge) and runs the RC4 key-scheduling algorithm on it. It optionally fills S[k]=k, then, for i=0..255: j=j+S[i]+key[i mod KEY_BYTES], then swaps S[i] and S[j]. It sits between the top-level control FSM (start/done handshake) and the S-memory address/data/wren pins. A later PRGA block reuses the memory once done is high.

Parameters:
KEY_BYTES, 3, number of secret-key bytes; byte 0 is the most significant byte of secret_key.
ADDR_WIDTH, 8, S-memory address width; the block is specified for 8 only (256 entries).
DATA_WIDTH, 8, S-memory data width.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
start  in  1  level-sampled request; accepted only in IDLE or DONE.
secret_key  in  KEY_BYTES*8  key; sampled into a register when start is accepted.
mem_q  in  DATA_WIDTH  S-memory read data; valid the cycle after the address is presented.
mem_address  out  ADDR_WIDTH  S-memory address (registered).
mem_data  out  DATA_WIDTH  S-memory write data (registered).
mem_wren  out  1  S-memory write enable (registered).
busy  out  1  high from the accepting edge until DONE is entered.
done  out  1  high in DONE; held until the next accepted start or reset.

Behaviour:
- Reset values: mem_address=0, mem_data=0, mem_wren=0, busy=0, done=0. Internal i=0, j=0, state=IDLE, and the key register=0.
- Reset mid-operation: the block returns to IDLE at once. Memory contents are partial and undefined. No write is issued after reset asserts.
- States: IDLE, INIT, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE.
- IDLE/DONE, start=1 -> INIT with i=0. The edge latches the key, clears j and done, and sets busy. start in any other state is ignored.
- INIT (256 cycles): drive address=i, data=i, wren=1, then i++. The edge writing i=255 moves to RD_I with i=0, j=0, wren=0.
- RD_I: address=i, wren=0.
- GET_I: capture si=mem_q. Set j <= j + mem_q + keybyte(i mod KEY_BYTES), mod 256.
- RD_J: address=j.
- GET_J: capture sj=mem_q.
- WR_I: address=i, data=sj, wren=1.
- WR_J: address=j, data=si, wren=1. If i==255 go to DONE, else i++ and go to RD_I.
- Each i costs exactly 6 cycles. No read-after-write hazard arises because every read targets a cycle after the prior write edge.
- DONE: wren=0, busy=0, done=1.
- Latency: done rises 1792 cycles after the accepting edge (256 INIT + 1536 KSA).
- Arithmetic: all index math is 8-bit with silent wrap. The key index is a counter 0..KEY_BYTES-1 advanced with i and reset at i wrap; no divider is used.
- i==j: both writes target the same address with the same value; this is legal and S is unchanged.
- start held high through DONE: a new run starts on the first DONE cycle, and done drops after one cycle.

Optional Feature:
KSA_INIT_EN
- Defined: the INIT phase runs as above.
- Undefined: INIT is removed and an accepted start goes directly to RD_I. The memory must already hold S[k]=k. done latency becomes 1536 cycles.

Test Plan:
- Reset then idle 10 cycles -> wren=0, busy=0, done=0, address=0 throughout.
- key=24'h000000, start pulse, stop after INIT -> 256 writes with address k, data k; memory model holds S[k]=k.
- key=24'h000000, full run -> i=0 and i=1 writes are no-ops (j=0, then j=1). For i=2, WR_I writes addr 2 data 3, then WR_J writes addr 3 data 2. The first write pair lands at cycles 261 and 262 after the accepting edge. done rises at cycle 1792.
- Random keys (KEY_BYTES=3), 20 runs -> final memory matches a software KSA model byte-for-byte, and the final memory is a permutation of 0..255.
- Assert reset at cycle 900 of a run -> all outputs 0 next edge; no further wren. A new start then completes normally with the correct result.
- start asserted mid-run, and start held high across DONE -> mid-run start ignored; held start restarts with done high exactly one cycle.
